io_reg_arbiter: RTL and testbench
=================================

IO_REG_ARBITER -- requirements
Module: io_reg_arbiter

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32 and set the width of the register data buses and requester data buses.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_a  input  1  requester A (HPS bus side) access request; held until ack_a.
REQ-005 wr_a  input  1  requester A: 1 = write, 0 = read; stable while req_a high.
REQ-006 addr_a  input  2  requester A register address: 0 = data_io, 1 = control, 2 = interrupt, 3 = unmapped.
REQ-007 wdata_a  input  DATA_WIDTH  requester A write data; stable while req_a high.
REQ-008 ack_a  output  1  one-cycle completion pulse to requester A.
REQ-009 req_b, wr_b, addr_b[1:0], wdata_b[DATA_WIDTH-1:0] are inputs and ack_b is a 1-bit output for requester B (internal game logic), with the same meanings as the A ports.
REQ-010 rdata  output  DATA_WIDTH  read result, valid in the ack cycle of a read.
REQ-011 read_addr  output  2  address driven to the register read mux.
REQ-012 read_data  input  DATA_WIDTH  combinational data returned by the register read mux for read_addr.
REQ-013 wr_en  output  3  one-hot write strobes: bit0 data_io, bit1 control, bit2 interrupt.
REQ-014 wr_data  output  DATA_WIDTH  write data to the register bank.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, and DONE.
REQ-017 In IDLE with no request, the FSM SHALL remain in IDLE.
REQ-018 In IDLE with any request, the FSM SHALL latch the winner's wr, addr, and wdata and the winner identity, then go to ACCESS.
REQ-019 Arbitration SHALL be round-robin: with a single requester, that requester wins.
REQ-020 With req_a and req_b both high in the same cycle, the requester not granted last SHALL win.
REQ-021 The last-grant pointer SHALL reset to B, so A wins the first tie.
REQ-022 In ACCESS, read_addr SHALL equal the latched address for exactly one cycle.
REQ-023 A latched write in ACCESS SHALL assert only the wr_en bit matching the address, with wr_data equal to the latched data.
REQ-024 A write to address 3 SHALL assert no wr_en bit but SHALL still complete with an ack.
REQ-025 A latched read in ACCESS SHALL capture read_data into rdata at the end of the cycle.
REQ-026 A read of address 3 SHALL load rdata with zero.
REQ-027 ACCESS SHALL always go to DONE.
REQ-028 In DONE, the FSM SHALL pulse ack_a or ack_b (never both) for one cycle, then return to IDLE.
REQ-029 Latency SHALL be fixed: request sampled in IDLE at cycle N, access at N+1, ack at N+2, new request sampled no earlier than N+3.
REQ-030 A requester SHALL deassert req in the cycle after its ack; a req still high in IDLE SHALL be treated as a new transaction.
REQ-031 A losing requester's req SHALL remain pending, with no loss, and SHALL be served in the next IDLE cycle.
REQ-032 Outside ACCESS, wr_en SHALL be 0, and read_addr and wr_data SHALL hold their last values.
REQ-033 rdata SHALL hold its value until the next read capture; writes SHALL not alter it.
REQ-034 Request inputs SHALL be ignored while busy is high.

Reset
REQ-035 Reset SHALL take priority over all other inputs and SHALL force the FSM to IDLE.
REQ-036 Reset SHALL drive ack_a, ack_b, wr_en, busy, read_addr, wr_data, and rdata to 0, and set the last-grant pointer to B.
REQ-037 Reset asserted during ACCESS or DONE SHALL abort the transaction with no ack and no further wr_en in the following cycles.

Verification
REQ-038 A-only write (wr_a=1, addr_a=1, wdata_a=0x0000_00A5) -> wr_en=3'b010 with wr_data=0x0000_00A5 one cycle after the req sample, ack_a one cycle later, ack_b never.
REQ-039 B-only read (addr_b=2, read_data model returns 0x0000_0004) -> read_addr=2 in ACCESS, ack_b with rdata=0x0000_0004.
REQ-040 Simultaneous req_a and req_b held continuously after reset -> grants alternate A, B, A, B, with acks 3 cycles apart and no lost request.
REQ-041 Address 3 read then write from A -> rdata=0x0000_0000, wr_en stays 0, ack_a asserted both times.
REQ-042 Reset pulsed in the ACCESS cycle of a write -> wr_en=0 from the next cycle, no ack, busy=0, FSM in IDLE.
REQ-043 req_b held high one cycle past ack_b -> a second B transaction starts, and the A/B round-robin order is preserved when req_a joins.

Source files
------------

// File: rtl/io_reg_arbiter.sv
// Round-robin arbiter giving two requesters (HPS bus side, game logic) serialized
// access to a small register bank through a fixed IDLE -> ACCESS -> DONE sequence.
module io_reg_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  wr_a,
  input  logic [1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  ack_a,
  input  logic                  req_b,
  input  logic                  wr_b,
  input  logic [1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  ack_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [2:0]            wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_b_q, last_b_d;
  logic                    sel_b_q, sel_b_d;
  logic                    lat_wr_q, lat_wr_d;
  logic                    ack_a_q, ack_a_d;
  logic                    ack_b_q, ack_b_d;
  logic                    busy_q, busy_d;
  logic [2:0]              wr_en_q, wr_en_d;
  logic [1:0]              read_addr_q, read_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    grant_b;
  logic                    win_wr;
  logic [1:0]              win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;

  function automatic logic [2:0] wr_strobe(input logic [1:0] addr);
    case (addr)
      2'd0:    wr_strobe = 3'b001;
      2'd1:    wr_strobe = 3'b010;
      2'd2:    wr_strobe = 3'b100;
      default: wr_strobe = 3'b000;
    endcase
  endfunction

  // On a tie A wins only when B holds the last grant; a lone requester always wins.
  assign grant_b   = req_b & (~req_a | ~last_b_q);
  assign win_wr    = grant_b ? wr_b    : wr_a;
  assign win_addr  = grant_b ? addr_b  : addr_a;
  assign win_wdata = grant_b ? wdata_b : wdata_a;

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    sel_b_d     = sel_b_q;
    lat_wr_d    = lat_wr_q;
    read_addr_d = read_addr_q;
    wr_data_d   = wr_data_q;
    rdata_d     = rdata_q;
    wr_en_d     = 3'b000;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d     = ACCESS;
          last_b_d    = grant_b;
          sel_b_d     = grant_b;
          lat_wr_d    = win_wr;
          read_addr_d = win_addr;
          if (win_wr) begin
            wr_data_d = win_wdata;
            wr_en_d   = wr_strobe(win_addr);
          end else begin
            wr_data_d = wr_data_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = DONE;
        ack_a_d = ~sel_b_q;
        ack_b_d = sel_b_q;
        // The unmapped address reads as zero regardless of what the mux returns.
        if (!lat_wr_q) begin
          rdata_d = (read_addr_q == 2'd3) ? {DATA_WIDTH{1'b0}} : read_data;
        end else begin
          rdata_d = rdata_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      sel_b_q     <= 1'b0;
      lat_wr_q    <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 3'b000;
      read_addr_q <= 2'd0;
      wr_data_q   <= {DATA_WIDTH{1'b0}};
      rdata_q     <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      sel_b_q     <= sel_b_d;
      lat_wr_q    <= lat_wr_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      read_addr_q <= read_addr_d;
      wr_data_q   <= wr_data_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign busy      = busy_q;
  assign wr_en     = wr_en_q;
  assign read_addr = read_addr_q;
  assign wr_data   = wr_data_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_io_reg_arbiter.sv
// Scenario-driven bench for io_reg_arbiter: expected grants are queued as requests
// are driven and popped when the matching ack appears.
module tb_io_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, wr_a, req_b, wr_b;
  logic [1:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        ack_a, ack_b, busy;
  logic [31:0] rdata, read_data, wr_data;
  logic [1:0]  read_addr;
  logic [2:0]  wr_en;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_b;
    logic        wr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  io_reg_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a),
    .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b),
    .rdata(rdata), .read_addr(read_addr), .read_data(read_data),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy)
  );

  function automatic logic [31:0] rd_model(input logic [1:0] a);
    case (a)
      2'd0:    rd_model = 32'h1111_0000;
      2'd1:    rd_model = 32'h2222_0001;
      2'd2:    rd_model = 32'h0000_0004;
      default: rd_model = 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb read_data = rd_model(read_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_a = 1'b0; wr_a = 1'b0; addr_a = 2'd0; wdata_a = 32'h0;
    req_b = 1'b0; wr_b = 1'b0; addr_b = 2'd0; wdata_b = 32'h0;
    step(); step();
    total++; if ({ack_a, ack_b, busy} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: got ack_a/ack_b/busy=%b expected 000", {ack_a, ack_b, busy}); end
    total++; if (wr_en !== 3'b000) begin bad++; $display("FAIL reset_wr_en: got %b expected 000", wr_en); end
    total++; if (read_addr !== 2'd0) begin bad++; $display("FAIL reset_read_addr: got %0d expected 0", read_addr); end
    total++; if (wr_data !== 32'h0) begin bad++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_a();
    req_a = 1'b1; wr_a = 1'b1; addr_a = 2'd1; wdata_a = 32'h0000_00A5;
    exp_q.push_back('{1'b0, 1'b1, 32'h0});
    step();
    total++; if (wr_en !== 3'b010) begin bad++; $display("FAIL wa_wr_en: got %b expected 010", wr_en); end
    total++; if (wr_data !== 32'h0000_00A5) begin bad++; $display("FAIL wa_wr_data: got %h expected 000000a5", wr_data); end
    total++; if ({busy, ack_a, ack_b} !== 3'b100) begin bad++; $display("FAIL wa_access: got busy/ack_a/ack_b=%b expected 100", {busy, ack_a, ack_b}); end
    step();
    total++; if ({ack_a, ack_b} !== 2'b10) begin bad++; $display("FAIL wa_ack: got ack_a/ack_b=%b expected 10", {ack_a, ack_b}); end
    total++; if (wr_en !== 3'b000) begin bad++; $display("FAIL wa_done_wr_en: got %b expected 000", wr_en); end
    e = exp_q.pop_front();
    req_a = 1'b0;
    step();
    total++; if ({busy, ack_a, ack_b} !== 3'b000) begin bad++; $display("FAIL wa_idle: got busy/ack_a/ack_b=%b expected 000", {busy, ack_a, ack_b}); end
  endtask

  task automatic test_read_b();
    req_b = 1'b1; wr_b = 1'b0; addr_b = 2'd2; wdata_b = 32'h0;
    exp_q.push_back('{1'b1, 1'b0, rd_model(2'd2)});
    step();
    total++; if (read_addr !== 2'd2) begin bad++; $display("FAIL rb_read_addr: got %0d expected 2", read_addr); end
    total++; if (wr_en !== 3'b000) begin bad++; $display("FAIL rb_wr_en: got %b expected 000", wr_en); end
    step();
    e = exp_q.pop_front();
    total++; if ({ack_a, ack_b} !== {~e.is_b, e.is_b}) begin bad++; $display("FAIL rb_ack: got ack_a/ack_b=%b expected %b", {ack_a, ack_b}, {~e.is_b, e.is_b}); end
    total++; if (rdata !== e.data) begin bad++; $display("FAIL rb_rdata: got %h expected %h", rdata, e.data); end
    req_b = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic ea, eb;
    reset = 1'b1; step(); reset = 1'b0;
    req_a = 1'b1; wr_a = 1'b1; addr_a = 2'd0; wdata_a = 32'h0000_0011;
    req_b = 1'b1; wr_b = 1'b0; addr_b = 2'd1;
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back('{1'b0, 1'b1, 32'h0});
      exp_q.push_back('{1'b1, 1'b0, rd_model(2'd1)});
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      ea = (k == 2 || k == 8);
      eb = (k == 5 || k == 11);
      total++; if (ack_a !== ea) begin bad++; $display("FAIL rr_ack_a[%0d]: got %b expected %b", k, ack_a, ea); end
      total++; if (ack_b !== eb) begin bad++; $display("FAIL rr_ack_b[%0d]: got %b expected %b", k, ack_b, eb); end
      if (ack_a === 1'b1 || ack_b === 1'b1) begin
        e = exp_q.pop_front();
        if (!e.wr) begin
          total++; if (rdata !== e.data) begin bad++; $display("FAIL rr_rdata[%0d]: got %h expected %h", k, rdata, e.data); end
        end
      end
      if (k == 1 || k == 7) begin
        total++; if (wr_en !== 3'b001 || wr_data !== 32'h0000_0011) begin bad++; $display("FAIL rr_write[%0d]: got wr_en=%b wr_data=%h expected 001/00000011", k, wr_en, wr_data); end
      end
      if (k == 8) begin
        total++; if (rdata !== rd_model(2'd1)) begin bad++; $display("FAIL rr_rdata_hold: got %h expected %h", rdata, rd_model(2'd1)); end
      end
      if (k == 11) begin req_a = 1'b0; req_b = 1'b0; end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_addr3();
    req_a = 1'b1; wr_a = 1'b0; addr_a = 2'd3; wdata_a = 32'h0;
    exp_q.push_back('{1'b0, 1'b0, 32'h0});
    step();
    total++; if (read_addr !== 2'd3 || wr_en !== 3'b000) begin bad++; $display("FAIL a3r_access: got read_addr=%0d wr_en=%b expected 3/000", read_addr, wr_en); end
    step();
    e = exp_q.pop_front();
    total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL a3r_ack: got %b expected 1", ack_a); end
    total++; if (rdata !== e.data) begin bad++; $display("FAIL a3r_rdata: got %h expected %h", rdata, e.data); end
    req_a = 1'b0;
    step();
    req_a = 1'b1; wr_a = 1'b1; addr_a = 2'd3; wdata_a = 32'hFFFF_FFFF;
    exp_q.push_back('{1'b0, 1'b1, 32'h0});
    step();
    total++; if (wr_en !== 3'b000) begin bad++; $display("FAIL a3w_wr_en: got %b expected 000", wr_en); end
    step();
    e = exp_q.pop_front();
    total++; if ({ack_a, ack_b} !== 2'b10) begin bad++; $display("FAIL a3w_ack: got ack_a/ack_b=%b expected 10", {ack_a, ack_b}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL a3w_rdata_hold: got %h expected 0", rdata); end
    req_a = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    req_a = 1'b1; wr_a = 1'b1; addr_a = 2'd2; wdata_a = 32'h0000_005A;
    step();
    total++; if (wr_en !== 3'b100) begin bad++; $display("FAIL ab_access_wr_en: got %b expected 100", wr_en); end
    reset = 1'b1; req_a = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if ({ack_a, ack_b, busy, wr_en} !== 6'b000000) begin bad++; $display("FAIL ab_after[%0d]: got ack_a/ack_b/busy/wr_en=%b expected 000000", k, {ack_a, ack_b, busy, wr_en}); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic ea, eb;
    req_b = 1'b1; wr_b = 1'b0; addr_b = 2'd0;
    exp_q.push_back('{1'b1, 1'b0, rd_model(2'd0)});
    exp_q.push_back('{1'b1, 1'b0, rd_model(2'd0)});
    exp_q.push_back('{1'b0, 1'b1, 32'h0});
    exp_q.push_back('{1'b1, 1'b0, rd_model(2'd0)});
    exp_q.push_back('{1'b0, 1'b1, 32'h0});
    for (int k = 1; k <= 15; k++) begin
      step();
      ea = (k == 8 || k == 14);
      eb = (k == 2 || k == 5 || k == 11);
      total++; if (ack_a !== ea) begin bad++; $display("FAIL bb_ack_a[%0d]: got %b expected %b", k, ack_a, ea); end
      total++; if (ack_b !== eb) begin bad++; $display("FAIL bb_ack_b[%0d]: got %b expected %b", k, ack_b, eb); end
      if (ack_a === 1'b1 || ack_b === 1'b1) begin
        e = exp_q.pop_front();
        if (!e.wr) begin
          total++; if (rdata !== e.data) begin bad++; $display("FAIL bb_rdata[%0d]: got %h expected %h", k, rdata, e.data); end
        end
      end
      if (k == 7 || k == 13) begin
        total++; if (wr_en !== 3'b010 || wr_data !== 32'h0000_0077) begin bad++; $display("FAIL bb_write[%0d]: got wr_en=%b wr_data=%h expected 010/00000077", k, wr_en, wr_data); end
      end
      if (k == 4) begin req_a = 1'b1; wr_a = 1'b1; addr_a = 2'd1; wdata_a = 32'h0000_0077; end
      if (k == 5) req_b = 1'b0;
      if (k == 8) req_b = 1'b1;
      if (k == 11) req_b = 1'b0;
      if (k == 14) req_a = 1'b0;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bb_idle_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_b();
    test_round_robin();
    test_addr3();
    test_reset_abort();
    test_back_to_back();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
